pair_dist_scanner: RTL
======================

Name: pair_dist_scanner

Overview:
- Hardware accelerator for Program 2: finds min and max absolute distance over all unordered pairs of 32 signed 16-bit values held in byte-wide data memory.
- Sits beside data_mem as a memory master. Consumes the operand image loaded into core[0:63] and produces the results in core[66:69].
- Uses the same start/done protocol as top_level.

Parameters:
- N_VALS, 32: number of 16-bit operands; pairs scanned = N_VALS*(N_VALS-1)/2.
- SRC_BASE, 0: byte address of first operand; operand i is at SRC_BASE+2i (high byte) and SRC_BASE+2i+1 (low byte).
- RES_BASE, 66: byte address of results. Min goes to RES_BASE/+1, max goes to RES_BASE+2/+3, high byte first.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; high = hold/arm, falling to low launches a run.
- done  out  1  high when results are written; held until start goes high.
- mem_addr  out  8  byte address to data_mem.
- mem_rdata  in  8  data_mem read data, combinational (same-cycle) read.
- mem_wr_en  out  1  write strobe, one byte per cycle.
- mem_wdata  out  8  write data.
- min_dist  out  16  running/final minimum distance.
- max_dist  out  16  running/final maximum distance.
- min_j, min_k, max_j, max_k  out  5 each  operand indices of the winning pairs (j<k).

Behaviour:
- Reset is synchronous and active-high. It has priority over start.
- Reset values: state=HALT, done=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, min_dist=16'hFFFF, max_dist=0, all indices=0.
- States: HALT, IDLE, LOAD, SCAN, WRITE, DONE.
- start high in any state (except during reset) -> IDLE next cycle. This is a soft abort: done=0, no writes, and min/max are reinitialised to FFFF/0.
- IDLE with start low -> LOAD. HALT ignores start low, so no run happens out of reset until start has been high.
- LOAD, 64 cycles:
  - mem_addr steps from SRC_BASE to SRC_BASE+63.
  - Each byte is captured the same cycle into a 32x16 internal register file, even byte = [15:8].
- SCAN, 496 cycles, one pair per cycle, order j=0..30, k=j+1..31:
  - diff = 17-bit sign-extended a_j - a_k.
  - dist = |diff| truncated to 16 bits. It never overflows: max 65535.
  - Update min only if dist < min_dist (strict). Update max only if dist > max_dist (strict). So on a tie the first pair in scan order wins.
  - Indices are updated together with their value.
- WRITE, 4 cycles:
  - mem_wr_en=1 with addresses RES_BASE..RES_BASE+3.
  - Data in order: min[15:8], min[7:0], max[15:8], max[7:0].
- DONE: done=1, mem_wr_en=0. Stays until start high.
- Latency: done goes high exactly 564 clk edges after the edge that moves IDLE->LOAD.
- mem_wr_en=0 in every state except WRITE. Memory is never written during LOAD/SCAN.
- Reset or start asserted mid-WRITE leaves a partially written result. The bench must not check results in that case.

Optional Feature:
- Macro: PAIR_IDX_WB_EN.
- Defined: WRITE lasts 8 cycles and additionally writes min_j, min_k, max_j, max_k (zero-extended to 8 bits) to RES_BASE+4..RES_BASE+7. Done latency becomes 568.
- Undefined: 4-cycle WRITE, latency 564. Indices are available on ports only, and core[70:73] is untouched.

Test Plan:
- Operand i = i*100 (i=0..31) -> min=100 at (0,1); max=3100 at (0,31); core[66:69]=00,64,0C,1C; done 564 cycles after IDLE->LOAD.
- All operands 0 -> min=0 (0,1), max=0 (0,1), core[66:69]=0.
- a0=-32768, a1=32767, rest 0 -> max=65535 at (0,1); min=0 at (2,3); core[68:69]=FF,FF.
- Tie case: a0=0, a1=10, a2=20, a3=30, rest 1000*i -> min=10 kept at (0,1), not (1,2) or (2,3).
- start raised at cycle 200 of SCAN -> IDLE next cycle, done=0, core[66:69] keep preset FFFF/0000. Lowering start again gives a full correct rerun.
- reset pulsed mid-LOAD -> HALT with all reset values. start low alone does not launch; start high then low launches a correct run.

Source files
------------

// File: rtl/pair_dist_scanner.sv
// ---------------------------------------------------------------------------
// pair_dist_scanner
// Memory-master accelerator that loads N_VALS signed 16-bit operands from a
// byte-wide data memory. It scans every unordered pair (j<k) and writes the
// minimum and maximum absolute distance back to memory, high byte first.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      high = hold/abort, falling low launches a run from IDLE
//   done       high once results are written, held until start goes high
//   mem_addr   byte address to data memory
//   mem_rdata  data memory read data (combinational read of mem_addr)
//   mem_wr_en  write strobe, one byte per cycle, only in WRITE
//   mem_wdata  write data
//   min_dist   running/final minimum distance
//   max_dist   running/final maximum distance
//   min_j/min_k, max_j/max_k  operand indices of the winning pairs (j<k)
//
// Optional feature (macro PAIR_IDX_WB_EN): WRITE lasts 8 cycles and also
// stores min_j, min_k, max_j, max_k (zero-extended) at RES_BASE+4..+7.
// ---------------------------------------------------------------------------
module pair_dist_scanner #(
    parameter int unsigned N_VALS   = 32,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned RES_BASE = 66,
    localparam int unsigned IDX_W   = $clog2(N_VALS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             done,
    output logic [7:0]       mem_addr,
    input  logic [7:0]       mem_rdata,
    output logic             mem_wr_en,
    output logic [7:0]       mem_wdata,
    output logic [15:0]      min_dist,
    output logic [15:0]      max_dist,
    output logic [IDX_W-1:0] min_j,
    output logic [IDX_W-1:0] min_k,
    output logic [IDX_W-1:0] max_j,
    output logic [IDX_W-1:0] max_k
);

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 8;
    localparam int unsigned LOAD_BYTES = 2 * N_VALS;
    localparam int unsigned BW         = $clog2(LOAD_BYTES);
    localparam int unsigned WCW        = 3;
`ifdef PAIR_IDX_WB_EN
    localparam int unsigned WR_BYTES   = 8;
`else
    localparam int unsigned WR_BYTES   = 4;
`endif

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_SCAN  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0]    vals_q [N_VALS];
    logic [DW-1:0]    vals_d [N_VALS];

    logic [IDX_W-1:0] j_q, j_d, k_q, k_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             done_q, done_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]    min_q, min_d, max_q, max_d;
    logic [IDX_W-1:0] min_j_q, min_j_d, min_k_q, min_k_d;
    logic [IDX_W-1:0] max_j_q, max_j_d, max_k_q, max_k_d;

    // Status decodes for the current cycle.
    logic          load_last_c;
    logic          scan_last_c;
    logic          wr_last_c;
    logic          first_pair_c;
    logic [BW-1:0] ld_byte_c;
    logic [DW:0]   diff_c;
    logic [DW:0]   abs_c;
    logic [DW-1:0] dist_c;

    assign load_last_c  = (mem_addr_q == AW'(SRC_BASE + LOAD_BYTES - 1));
    assign scan_last_c  = (j_q == IDX_W'(N_VALS - 2)) && (k_q == IDX_W'(N_VALS - 1));
    assign wr_last_c    = (wcnt_q == WCW'(WR_BYTES - 1));
    assign first_pair_c = (j_q == IDX_W'(0)) && (k_q == IDX_W'(1));
    assign ld_byte_c    = BW'(mem_addr_q - AW'(SRC_BASE));

    // Pair distance: 17-bit signed difference, magnitude always fits 16 bits.
    always_comb begin
        diff_c = {vals_q[j_q][DW-1], vals_q[j_q]} - {vals_q[k_q][DW-1], vals_q[k_q]};
        abs_c  = diff_c[DW] ? ((DW+1)'(0) - diff_c) : diff_c;
        dist_c = abs_c[DW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start high aborts from anywhere to IDLE.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_HALT:  state_d = S_HALT;
                S_IDLE:  state_d = S_LOAD;
                S_LOAD:  if (load_last_c) state_d = S_SCAN;
                S_SCAN:  if (scan_last_c) state_d = S_WRITE;
                S_WRITE: if (wr_last_c)   state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_HALT;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        vals_d      = vals_q;
        j_d         = j_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wr_en_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        min_d       = min_q;
        max_d       = max_q;
        min_j_d     = min_j_q;
        min_k_d     = min_k_q;
        max_j_d     = max_j_q;
        max_k_d     = max_k_q;
        done_d      = (state_d == S_DONE);

        if (start) begin
            // Soft abort: discard partial results, stop driving memory.
            min_d       = '1;
            max_d       = '0;
            min_j_d     = '0;
            min_k_d     = '0;
            max_j_d     = '0;
            max_k_d     = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    min_d      = '1;
                    max_d      = '0;
                    min_j_d    = '0;
                    min_k_d    = '0;
                    max_j_d    = '0;
                    max_k_d    = '0;
                    j_d        = IDX_W'(0);
                    k_d        = IDX_W'(1);
                    mem_addr_d = AW'(SRC_BASE);
                end

                S_LOAD: begin
                    // Even byte is the operand's high half.
                    if (ld_byte_c[0] == 1'b0) begin
                        vals_d[ld_byte_c[BW-1:1]][15:8] = mem_rdata;
                    end else begin
                        vals_d[ld_byte_c[BW-1:1]][7:0]  = mem_rdata;
                    end
                    if (!load_last_c) begin
                        mem_addr_d = mem_addr_q + AW'(1);
                    end
                end

                S_SCAN: begin
                    // The first pair seeds both trackers so a degenerate image
                    // still reports (0,1); afterwards strict compares keep the
                    // earliest pair on ties.
                    if (first_pair_c || (dist_c < min_q)) begin
                        min_d   = dist_c;
                        min_j_d = j_q;
                        min_k_d = k_q;
                    end
                    if (first_pair_c || (dist_c > max_q)) begin
                        max_d   = dist_c;
                        max_j_d = j_q;
                        max_k_d = k_q;
                    end
                    if (k_q == IDX_W'(N_VALS - 1)) begin
                        j_d = j_q + IDX_W'(1);
                        k_d = j_q + IDX_W'(2);
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                    if (scan_last_c) begin
                        mem_wr_en_d = 1'b1;
                        mem_addr_d  = AW'(RES_BASE);
                        wcnt_d      = '0;
                    end
                end

                S_WRITE: begin
                    if (!wr_last_c) begin
                        mem_wr_en_d = 1'b1;
                        mem_addr_d  = mem_addr_q + AW'(1);
                        wcnt_d      = wcnt_q + WCW'(1);
                    end
                end

                default: ;
            endcase

            // Result byte select; uses the _d values so the first byte sees
            // the final pair's update.
            if (mem_wr_en_d) begin
                case (wcnt_d)
                    3'd0:    mem_wdata_d = min_d[15:8];
                    3'd1:    mem_wdata_d = min_d[7:0];
                    3'd2:    mem_wdata_d = max_d[15:8];
                    3'd3:    mem_wdata_d = max_d[7:0];
`ifdef PAIR_IDX_WB_EN
                    3'd4:    mem_wdata_d = 8'(min_j_d);
                    3'd5:    mem_wdata_d = 8'(min_k_d);
                    3'd6:    mem_wdata_d = 8'(max_j_d);
                    3'd7:    mem_wdata_d = 8'(max_k_d);
`endif
                    default: mem_wdata_d = 8'h00;
                endcase
            end
        end
    end

    // Operand register file (contents are don't-care until loaded).
    always_ff @(posedge clk) begin
        vals_q <= vals_d;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            j_q         <= '0;
            k_q         <= '0;
            wcnt_q      <= '0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
            min_q       <= '1;
            max_q       <= '0;
            min_j_q     <= '0;
            min_k_q     <= '0;
            max_j_q     <= '0;
            max_k_q     <= '0;
        end else begin
            j_q         <= j_d;
            k_q         <= k_d;
            wcnt_q      <= wcnt_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            min_q       <= min_d;
            max_q       <= max_d;
            min_j_q     <= min_j_d;
            min_k_q     <= min_k_d;
            max_j_q     <= max_j_d;
            max_k_q     <= max_k_d;
        end
    end

    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
    assign min_dist  = min_q;
    assign max_dist  = max_q;
    assign min_j     = min_j_q;
    assign min_k     = min_k_q;
    assign max_j     = max_j_q;
    assign max_k     = max_k_q;

endmodule
